// File: rtl/serial_sub.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock,
// using one full-adder cell fed with ~b and a carry flip-flop preset to 1.
module serial_sub #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         borrow,
    output logic         overflow,
    output logic         zero
);

    // state   | meaning
    // S_IDLE  | waiting for start; operands captured on the accepting edge
    // S_SHIFT | one result bit per edge, W edges in total
    // S_DONE  | one-cycle done pulse, start ignored
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam int            CW       = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  a_sh_q, a_sh_d;
    logic [W-1:0]  b_sh_q, b_sh_d;
    logic [W-1:0]  r_sh_q, r_sh_d;
    logic          carry_q, carry_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          a_msb_q, a_msb_d;
    logic          b_msb_q, b_msb_d;
    logic [W-1:0]  diff_q, diff_d;
    logic          borrow_q, borrow_d;
    logic          overflow_q, overflow_d;
    logic          zero_q, zero_d;

    logic          sum_bit;
    logic          carry_nxt;
    logic [W-1:0]  r_nxt;

    assign sum_bit   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign carry_nxt = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
    assign r_nxt     = {sum_bit, r_sh_q[W-1:1]};

    always_comb begin
        state_d    = state_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        r_sh_d     = r_sh_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        a_msb_d    = a_msb_q;
        b_msb_d    = b_msb_q;
        diff_d     = diff_q;
        borrow_d   = borrow_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = ~b;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    a_msb_d = a[W-1];
                    b_msb_d = b[W-1];
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                carry_d = carry_nxt;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                r_sh_d  = r_nxt;
                cnt_d   = cnt_q + CNT_ONE;
                // Last bit: publish the result including this edge's sum bit.
                if (cnt_q == CNT_LAST) begin
                    diff_d     = r_nxt;
                    borrow_d   = ~carry_nxt;
                    overflow_d = (a_msb_q != b_msb_q) && (r_nxt[W-1] != a_msb_q);
                    zero_d     = (r_nxt == '0);
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            r_sh_q     <= '0;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            a_msb_q    <= 1'b0;
            b_msb_q    <= 1'b0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            r_sh_q     <= r_sh_d;
            carry_q    <= carry_d;
            cnt_q      <= cnt_d;
            a_msb_q    <= a_msb_d;
            b_msb_q    <= b_msb_d;
            diff_q     <= diff_d;
            borrow_q   <= borrow_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
        end
    end

    assign busy     = (state_q == S_SHIFT);
    assign done     = (state_q == S_DONE);
    assign diff     = diff_q;
    assign borrow   = borrow_q;
    assign overflow = overflow_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub: directed vectors at W=4 and W=8, expected
// results queued at issue time and checked by per-instance done monitors.
module tb_serial_sub;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start4, busy4, done4, borrow4, ovf4, zero4;
    logic [3:0] a4, b4, diff4;
    logic       start8, busy8, done8, borrow8, ovf8, zero8;
    logic [7:0] a8, b8, diff8;

    serial_sub #(.W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4),
        .overflow(ovf4), .zero(zero4)
    );

    serial_sub #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8),
        .overflow(ovf8), .zero(zero8)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [6:0]  q4[$];  // {diff, borrow, overflow, zero}
    logic [10:0] q8[$];
    logic [3:0]  hold4 = '0;
    logic [7:0]  hold8 = '0;
    logic        done4_prev = 1'b0;
    logic        done8_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitors: pop one expected result per done pulse.
    always @(negedge clk) begin
        if (done4) begin
            chk("busy_low_at_done4", 32'(busy4), 32'd0);
            chk("done_one_cycle4", 32'(done4_prev), 32'd0);
            if (q4.size() == 0) begin
                chk("unexpected_done4", 32'd1, 32'd0);
            end else begin
                logic [6:0] e;
                e = q4.pop_front();
                chk("diff4", 32'(diff4), 32'(e[6:3]));
                chk("borrow4", 32'(borrow4), 32'(e[2]));
                chk("overflow4", 32'(ovf4), 32'(e[1]));
                chk("zero4", 32'(zero4), 32'(e[0]));
            end
        end
        done4_prev <= done4;
    end

    always @(negedge clk) begin
        if (done8) begin
            chk("busy_low_at_done8", 32'(busy8), 32'd0);
            chk("done_one_cycle8", 32'(done8_prev), 32'd0);
            if (q8.size() == 0) begin
                chk("unexpected_done8", 32'd1, 32'd0);
            end else begin
                logic [10:0] e;
                e = q8.pop_front();
                chk("diff8", 32'(diff8), 32'(e[10:3]));
                chk("borrow8", 32'(borrow8), 32'(e[2]));
                chk("overflow8", 32'(ovf8), 32'(e[1]));
                chk("zero8", 32'(zero8), 32'(e[0]));
            end
        end
        done8_prev <= done8;
    end

    task automatic run_op4(input logic [3:0] av, input logic [3:0] bv, input logic [3:0] ed,
                           input logic eb, input logic eo, input logic ez);
        int nb, n;
        @(negedge clk);
        a4 = av; b4 = bv; start4 = 1'b1;
        q4.push_back({ed, eb, eo, ez});
        @(negedge clk);
        start4 = 1'b0;
        nb = 0; n = 0;
        while (!done4 && n < 20) begin
            if (busy4) begin
                nb++;
                chk("diff4_hold_in_shift", 32'(diff4), 32'(hold4));
            end
            a4 = 4'($urandom); b4 = 4'($urandom);
            @(negedge clk);
            n++;
        end
        chk("done4_within_bound", 32'(done4), 32'd1);
        chk("busy4_cycles", 32'(nb), 32'd4);
        hold4 = ed;
    endtask

    task automatic run_op8(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] ed,
                           input logic eb, input logic eo, input logic ez);
        int nb, n;
        @(negedge clk);
        a8 = av; b8 = bv; start8 = 1'b1;
        q8.push_back({ed, eb, eo, ez});
        @(negedge clk);
        start8 = 1'b0;
        nb = 0; n = 0;
        while (!done8 && n < 30) begin
            if (busy8) begin
                nb++;
                chk("diff8_hold_in_shift", 32'(diff8), 32'(hold8));
            end
            a8 = 8'($urandom); b8 = 8'($urandom);
            @(negedge clk);
            n++;
        end
        chk("done8_within_bound", 32'(done8), 32'd1);
        chk("busy8_cycles", 32'(nb), 32'd8);
        hold8 = ed;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int last_cyc, n, seen;
        rst = 1'b1;
        start4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs4", 32'({busy4, done4, borrow4, ovf4, zero4, diff4}), 32'd0);
        chk("reset_outputs8", 32'({busy8, done8, borrow8, ovf8, zero8, diff8}), 32'd0);
        rst = 1'b0;

        run_op4(4'd7, 4'd3, 4'd4,  1'b0, 1'b0, 1'b0);
        run_op4(4'd3, 4'd7, 4'd12, 1'b1, 1'b0, 1'b0);
        run_op4(4'd5, 4'd5, 4'd0,  1'b0, 1'b0, 1'b1);
        run_op4(4'd0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b1);
        run_op4(4'b1000, 4'd1, 4'b0111, 1'b0, 1'b1, 1'b0);
        run_op4(4'd7, 4'b1111, 4'b1000, 1'b1, 1'b1, 1'b0);

        // start held high: 9 - 2 = 7 (signed -7 - 2 overflows), one result every 6 cycles
        @(negedge clk);
        a4 = 4'd9; b4 = 4'd2; start4 = 1'b1;
        repeat (3) q4.push_back({4'd7, 1'b0, 1'b1, 1'b0});
        last_cyc = 0;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            @(negedge clk);
            while (!done4 && n < 20) begin
                if (busy4) begin
                    chk("diff4_hold_streaming", 32'(diff4), 32'(hold4));
                    a4 = 4'($urandom); b4 = 4'($urandom);
                end else begin
                    a4 = 4'd9; b4 = 4'd2;
                end
                @(negedge clk);
                n++;
            end
            chk("stream_done4_within_bound", 32'(done4), 32'd1);
            if (k > 0) chk("stream_period4", 32'(cyc - last_cyc), 32'd6);
            last_cyc = cyc;
            hold4 = 4'd7;
            a4 = 4'd9; b4 = 4'd2;
            if (k == 2) start4 = 1'b0;
        end

        // abort 6 - 1 with reset during the second SHIFT cycle
        @(negedge clk);
        a4 = 4'd6; b4 = 4'd1; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        chk("busy4_before_abort", 32'(busy4), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_outputs4", 32'({busy4, done4, borrow4, ovf4, zero4, diff4}), 32'd0);
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (done4) seen++;
        end
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done4 || busy4) seen++;
        end
        chk("no_activity_after_abort4", 32'(seen), 32'd0);
        hold4 = 4'd0;
        run_op4(4'd6, 4'd1, 4'd5, 1'b0, 1'b0, 1'b0);

        run_op8(8'd200, 8'd55, 8'd145, 1'b0, 1'b0, 1'b0);
        run_op8(8'd55, 8'd200, 8'd111, 1'b1, 1'b0, 1'b0);
        run_op8(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
        run_op8(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        chk("queue4_drained", 32'(q4.size()), 32'd0);
        chk("queue8_drained", 32'(q8.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
